// File: rtl/spi_ram_arbiter_pkg.sv
// Shared command encodings, FSM states and field positions for the SPI/host RAM arbiter.
package spi_arb_pkg;

  localparam int unsigned DIN_W  = 10;
  localparam int unsigned DOUT_W = 8;

  localparam int unsigned CMD_MSB = 9;
  localparam int unsigned CMD_LSB = 8;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOCKED  = 2'd1,
    ST_WAIT_RD = 2'd2
  } state_t;

endpackage

// File: rtl/spi_ram_arbiter_if.sv
// Requester and RAM side signals of the arbiter; slave = arbiter view, master = surroundings.
interface spi_ram_arbiter_if;
  import spi_arb_pkg::*;

  logic [DIN_W-1:0]  req0_din;
  logic              req0_valid;
  logic              req0_ready;
  logic [DOUT_W-1:0] req0_dout;
  logic              req0_tx_valid;

  logic [DIN_W-1:0]  req1_din;
  logic              req1_valid;
  logic              req1_ready;
  logic [DOUT_W-1:0] req1_dout;
  logic              req1_tx_valid;

  logic [DIN_W-1:0]  ram_din;
  logic              ram_rx_valid;
  logic [DOUT_W-1:0] ram_dout;
  logic              ram_tx_valid;

  logic              rd_timeout;

  modport slave (
    input  req0_din, req0_valid, req1_din, req1_valid, ram_dout, ram_tx_valid,
    output req0_ready, req0_dout, req0_tx_valid,
    output req1_ready, req1_dout, req1_tx_valid,
    output ram_din, ram_rx_valid, rd_timeout
  );

  modport master (
    output req0_din, req0_valid, req1_din, req1_valid, ram_dout, ram_tx_valid,
    input  req0_ready, req0_dout, req0_tx_valid,
    input  req1_ready, req1_dout, req1_tx_valid,
    input  ram_din, ram_rx_valid, rd_timeout
  );
endinterface

// File: rtl/spi_ram_arbiter_rr_arb2.sv
// Combinational two-way round-robin select: rr_ptr breaks ties, a lone requester always wins.
module rr_arb2 (
  input  logic       i_valid0,
  input  logic       i_valid1,
  input  logic       i_rr_ptr,
  output logic [1:0] o_grant,
  output logic       o_winner
);
  logic w_any;

  always_comb begin
    w_any    = i_valid0 | i_valid1;
    o_winner = (i_valid0 & i_valid1) ? i_rr_ptr : i_valid1;
    o_grant  = {w_any & o_winner, w_any & ~o_winner};
  end
endmodule

// File: rtl/spi_ram_arbiter.sv
// Two-requester arbiter for the RAM command port, keeping addr/data pairs atomic.
// Optional read timeout in WAIT_RD is enabled by defining SPI_ARB_RD_TIMEOUT_EN.
module spi_ram_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned RD_TIMEOUT = 15,
  parameter int unsigned CNT_W      = 4
) (
  input logic               clk,
  input logic               rst,
  spi_ram_arbiter_if.slave  bus
);
  state_t            r_state;
  logic              r_owner;
  logic              r_rr_ptr;
  logic [DIN_W-1:0]  r_ram_din;
  logic              r_ram_rx_valid;
  logic [DOUT_W-1:0] r_dout0;
  logic [DOUT_W-1:0] r_dout1;
  logic              r_tx_valid0;
  logic              r_tx_valid1;

  logic [1:0]        w_grant;
  logic              w_winner;
  logic              w_ready0;
  logic              w_ready1;
  logic              w_acc;
  logic              w_acc_id;
  logic [DIN_W-1:0]  w_din;
  logic [1:0]        w_cmd;

  rr_arb2 u_rr_arb2 (
    .i_valid0 (bus.req0_valid),
    .i_valid1 (bus.req1_valid),
    .i_rr_ptr (r_rr_ptr),
    .o_grant  (w_grant),
    .o_winner (w_winner)
  );

  always_comb begin
    w_ready0 = 1'b0;
    w_ready1 = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready0 = w_grant[0];
        w_ready1 = w_grant[1];
      end
      ST_LOCKED: begin
        w_ready0 = ~r_owner;
        w_ready1 = r_owner;
      end
      default: ;
    endcase
    w_acc    = (bus.req0_valid & w_ready0) | (bus.req1_valid & w_ready1);
    w_acc_id = bus.req1_valid & w_ready1;
    w_din    = w_acc_id ? bus.req1_din : bus.req0_din;
    w_cmd    = w_din[CMD_MSB:CMD_LSB];
  end

`ifdef SPI_ARB_RD_TIMEOUT_EN
  logic [CNT_W-1:0] r_cnt;
  logic             r_rd_timeout;
  logic [CNT_W-1:0] w_cnt_next;

  assign w_cnt_next     = r_cnt + CNT_W'(1);
  assign bus.rd_timeout = r_rd_timeout;
`else
  logic w_unused_cfg;

  assign w_unused_cfg   = ^{RD_TIMEOUT, CNT_W, w_winner};
  assign bus.rd_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_owner        <= 1'b0;
      r_rr_ptr       <= 1'b0;
      r_ram_din      <= '0;
      r_ram_rx_valid <= 1'b0;
      r_dout0        <= '0;
      r_dout1        <= '0;
      r_tx_valid0    <= 1'b0;
      r_tx_valid1    <= 1'b0;
`ifdef SPI_ARB_RD_TIMEOUT_EN
      r_cnt          <= '0;
      r_rd_timeout   <= 1'b0;
`endif
    end else begin
      r_ram_rx_valid <= w_acc;
      r_tx_valid0    <= 1'b0;
      r_tx_valid1    <= 1'b0;
`ifdef SPI_ARB_RD_TIMEOUT_EN
      r_rd_timeout   <= 1'b0;
`endif
      if (w_acc) r_ram_din <= w_din;
      case (r_state)
        ST_IDLE, ST_LOCKED: begin
          if (w_acc) begin
            r_owner <= w_acc_id;
            case (w_cmd)
              CMD_WR_ADDR, CMD_RD_ADDR: r_state <= ST_LOCKED;
              CMD_WR_DATA: begin
                // Even a stray WR_DATA in IDLE counts as a release for fairness.
                r_state  <= ST_IDLE;
                r_rr_ptr <= ~w_acc_id;
              end
              default: begin
                r_state <= ST_WAIT_RD;
`ifdef SPI_ARB_RD_TIMEOUT_EN
                r_cnt   <= '0;
`endif
              end
            endcase
          end
        end
        ST_WAIT_RD: begin
          if (bus.ram_tx_valid) begin
            if (r_owner) begin
              r_dout1     <= bus.ram_dout;
              r_tx_valid1 <= 1'b1;
            end else begin
              r_dout0     <= bus.ram_dout;
              r_tx_valid0 <= 1'b1;
            end
            r_state  <= ST_IDLE;
            r_rr_ptr <= ~r_owner;
          end
`ifdef SPI_ARB_RD_TIMEOUT_EN
          else if (w_cnt_next == RD_TIMEOUT[CNT_W-1:0]) begin
            r_state      <= ST_IDLE;
            r_rr_ptr     <= ~r_owner;
            r_rd_timeout <= 1'b1;
          end else begin
            r_cnt <= w_cnt_next;
          end
`endif
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req0_ready    = w_ready0;
  assign bus.req1_ready    = w_ready1;
  assign bus.req0_dout     = r_dout0;
  assign bus.req1_dout     = r_dout1;
  assign bus.req0_tx_valid = r_tx_valid0;
  assign bus.req1_tx_valid = r_tx_valid1;
  assign bus.ram_din       = r_ram_din;
  assign bus.ram_rx_valid  = r_ram_rx_valid;
endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Scoreboard bench for spi_ram_arbiter: directed stimulus pushes expected RAM words and read data.
module tb_spi_ram_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_ram_arbiter_if bus();

  spi_ram_arbiter #(.RD_TIMEOUT(15), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass  = 0;
  int n_total = 0;
  logic [9:0] q_ram[$];
  logic [7:0] q_rd0[$];
  logic [7:0] q_rd1[$];
  int q_to = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic unexpected(input string name, input int act);
    n_total++;
    $display("FAIL %s: got unexpected event with value 0x%0h, none required", name, act);
  endtask

  // Monitor: every output event must match the head of its queue.
  always @(negedge clk) begin
    if (bus.ram_rx_valid) begin
      if (q_ram.size() == 0) unexpected("ram_rx_valid", bus.ram_din);
      else chk("ram_din", bus.ram_din, q_ram.pop_front());
    end
    if (bus.req0_tx_valid) begin
      if (q_rd0.size() == 0) unexpected("req0_tx_valid", bus.req0_dout);
      else chk("req0_dout", bus.req0_dout, q_rd0.pop_front());
    end
    if (bus.req1_tx_valid) begin
      if (q_rd1.size() == 0) unexpected("req1_tx_valid", bus.req1_dout);
      else chk("req1_dout", bus.req1_dout, q_rd1.pop_front());
    end
    if (bus.rd_timeout) begin
      if (q_to == 0) unexpected("rd_timeout", 1);
      else begin
        q_to--;
        chk("rd_timeout_tx0", bus.req0_tx_valid, 0);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_ram_din"}, bus.ram_din, 0);
    chk({tag, "_ram_rx_valid"}, bus.ram_rx_valid, 0);
    chk({tag, "_req0_dout"}, bus.req0_dout, 0);
    chk({tag, "_req1_dout"}, bus.req1_dout, 0);
    chk({tag, "_req0_tx_valid"}, bus.req0_tx_valid, 0);
    chk({tag, "_req1_tx_valid"}, bus.req1_tx_valid, 0);
    chk({tag, "_req0_ready"}, bus.req0_ready, 0);
    chk({tag, "_req1_ready"}, bus.req1_ready, 0);
    chk({tag, "_rd_timeout"}, bus.rd_timeout, 0);
  endtask

  task automatic send(input int n, input logic [9:0] w);
    logic got;
    got = 1'b0;
    if (n == 0) begin bus.req0_din = w; bus.req0_valid = 1'b1; end
    else begin bus.req1_din = w; bus.req1_valid = 1'b1; end
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = (n == 0) ? bus.req0_ready : bus.req1_ready;
    end
    if (!got) unexpected("send_no_ready", w);
    @(posedge clk); #1;
    if (n == 0) bus.req0_valid = 1'b0;
    else bus.req1_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.req0_din = '0; bus.req0_valid = 1'b0;
    bus.req1_din = '0; bus.req1_valid = 1'b0;
    bus.ram_dout = '0; bus.ram_tx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;

    // Continuous WR_DATA from both: grants alternate 0,1,0,1
    bus.req0_din = 10'h111; bus.req1_din = 10'h122;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    q_ram.push_back(10'h111); q_ram.push_back(10'h122);
    q_ram.push_back(10'h111); q_ram.push_back(10'h122);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("alt_ready0", bus.req0_ready, (i % 2) == 0);
      chk("alt_ready1", bus.req1_ready, (i % 2) == 1);
      if (i > 0) chk("alt_rx_latency", bus.ram_rx_valid, 1);
      @(posedge clk); #1;
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    @(negedge clk);
    chk("alt_last_rx_latency", bus.ram_rx_valid, 1);
    @(posedge clk); #1;

    // Atomic pair from req0 while req1 waits
    q_ram.push_back(10'h005); q_ram.push_back(10'h1AA); q_ram.push_back(10'h00F);
    bus.req1_din = 10'h00F; bus.req1_valid = 1'b1;
    bus.req0_din = 10'h005; bus.req0_valid = 1'b1;
    @(negedge clk);
    chk("pair_grant0", bus.req0_ready, 1);
    chk("pair_stall1_a", bus.req1_ready, 0);
    @(posedge clk); #1 bus.req0_din = 10'h1AA;
    @(negedge clk);
    chk("pair_locked0", bus.req0_ready, 1);
    chk("pair_stall1_b", bus.req1_ready, 0);
    @(posedge clk); #1 bus.req0_valid = 1'b0;
    @(negedge clk);
    chk("pair_release_grant1", bus.req1_ready, 1);
    @(posedge clk); #1 bus.req1_valid = 1'b0;
    q_ram.push_back(10'h100);
    send(1, 10'h100);

    // Read by req1: data returned only to req1
    q_ram.push_back(10'h205); q_ram.push_back(10'h300);
    send(1, 10'h205);
    send(1, 10'h300);
    bus.req0_din = 10'h1CC; bus.req0_valid = 1'b1;
    @(negedge clk);
    chk("waitrd_ready0", bus.req0_ready, 0);
    chk("waitrd_ready1", bus.req1_ready, 0);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.ram_dout = 8'hAA; bus.ram_tx_valid = 1'b1;
    q_rd1.push_back(8'hAA);
    @(posedge clk); #1;
    bus.ram_dout = 8'h00; bus.ram_tx_valid = 1'b0;
    @(negedge clk);
    chk("rd_req1_tx_valid", bus.req1_tx_valid, 1);
    chk("rd_req0_tx_valid", bus.req0_tx_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rd_pulse_width", bus.req1_tx_valid, 0);
    @(posedge clk); #1;

    // ram_tx_valid while IDLE is ignored
    bus.ram_dout = 8'h55; bus.ram_tx_valid = 1'b1;
    @(posedge clk); #1;
    bus.ram_tx_valid = 1'b0;
    @(negedge clk);
    chk("idle_tx0", bus.req0_tx_valid, 0);
    chk("idle_tx1", bus.req1_tx_valid, 0);
    chk("idle_dout0", bus.req0_dout, 8'h00);
    chk("idle_dout1", bus.req1_dout, 8'hAA);
    @(posedge clk); #1;

    // Reset while LOCKED by req1
    q_ram.push_back(10'h005);
    send(1, 10'h005);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("midrst");
    @(posedge clk); #1;
    q_ram.push_back(10'h133); q_ram.push_back(10'h144);
    bus.req0_din = 10'h133; bus.req1_din = 10'h144;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    @(negedge clk);
    chk("postrst_ready0", bus.req0_ready, 1);
    chk("postrst_ready1", bus.req1_ready, 0);
    @(posedge clk); #1 bus.req0_valid = 1'b0;
    @(negedge clk);
    chk("postrst_next1", bus.req1_ready, 1);
    @(posedge clk); #1 bus.req1_valid = 1'b0;

    // Read by req0 that the RAM never answers
    q_ram.push_back(10'h200); q_ram.push_back(10'h300);
    send(0, 10'h200);
    send(0, 10'h300);
`ifdef SPI_ARB_RD_TIMEOUT_EN
    begin
      int seen;
      seen = 0;
      q_to++;
      for (int i = 1; i <= 20 && seen == 0; i++) begin
        @(negedge clk);
        if (bus.rd_timeout) seen = i;
      end
      chk("timeout_cycle", seen, 16);
      @(posedge clk); #1;
      q_ram.push_back(10'h166); q_ram.push_back(10'h155);
      bus.req0_din = 10'h155; bus.req1_din = 10'h166;
      bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
      @(negedge clk);
      chk("post_timeout_ready1", bus.req1_ready, 1);
      chk("post_timeout_ready0", bus.req0_ready, 0);
      @(posedge clk); #1 bus.req1_valid = 1'b0;
      @(negedge clk);
      chk("post_timeout_next0", bus.req0_ready, 1);
      @(posedge clk); #1 bus.req0_valid = 1'b0;
    end
`else
    bus.req0_din = 10'h177; bus.req1_din = 10'h188;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("waitrd_stall", {bus.req0_ready, bus.req1_ready}, 0);
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
`endif

    repeat (3) @(negedge clk);
    chk("q_ram_drained", q_ram.size(), 0);
    chk("q_rd0_drained", q_rd0.size(), 0);
    chk("q_rd1_drained", q_rd1.size(), 0);
    chk("q_timeout_drained", q_to, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/spi_ram_arbiter.md
Name: spi_ram_arbiter

Overview:
- Shares the single-port RAM 10-bit command interface between two requesters: req0 (SPI slave) and req1 (local host/BIST).
- Keeps address/data command pairs atomic and returns read data only to the requester that issued the read.
- Sits between the SPI slave and the RAM in the top level; one clock domain.

Parameters:
- RD_TIMEOUT, 15, cycles to wait in WAIT_RD for ram_tx_valid before abandoning the read (used only with the optional feature).
- CNT_W, 4, width of the timeout counter; must satisfy 2^CNT_W > RD_TIMEOUT.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_din  in  10  SPI command word: [9:8] = cmd, [7:0] = payload.
- req0_valid  in  1  req0 command present.
- req0_ready  out  1  req0 command accepted this cycle when valid && ready.
- req0_dout  out  8  read data returned to req0.
- req0_tx_valid  out  1  one-cycle pulse qualifying req0_dout.
- req1_din, req1_valid, req1_ready, req1_dout, req1_tx_valid: same as req0, for requester 1.
- ram_din  out  10  command word to the RAM.
- ram_rx_valid  out  1  command strobe to the RAM.
- ram_dout  in  8  RAM read data.
- ram_tx_valid  in  1  RAM read data valid.
- rd_timeout  out  1  one-cycle pulse when a read is abandoned; tied 0 without the optional feature.

Behaviour:
- Command encodings: 00 = WR_ADDR, 01 = WR_DATA, 10 = RD_ADDR, 11 = RD_DATA.
- Reset state: state = IDLE, owner = 0, rr_ptr = 0 (req0 has priority), timeout counter = 0. All outputs = 0, including ram_din, ram_rx_valid, both dout buses, both tx_valid outputs, both ready outputs and rd_timeout.
- A reset in any state, including mid-pair or during WAIT_RD, aborts the operation and returns to IDLE. The owner is not notified.
- readyN is combinational from state, owner and the valids.
- IDLE: ready is asserted to the arbitration winner only.
  - If only one requester is valid, it wins.
  - If both are valid, the requester selected by rr_ptr wins.
  - The winner becomes owner.
- LOCKED: readyN = 1 only for N == owner. The other requester stalls.
- WAIT_RD: both ready outputs = 0.
- Accepted transfer: ram_din <= din and ram_rx_valid <= 1 on the next edge, so latency is 1 cycle. ram_rx_valid is otherwise 0. At most one transfer is accepted per cycle.
- Next state is set by the accepted cmd, in both IDLE and LOCKED:
  - 00 or 10 -> LOCKED.
  - 01 -> IDLE.
  - 11 -> WAIT_RD.
- A stray 01 or 11 in IDLE is legal and passes through; 01 leaves the state in IDLE.
- WAIT_RD: on ram_tx_valid, reqN_dout <= ram_dout and reqN_tx_valid <= 1 for N == owner, 1-cycle latency. The pulse lasts one cycle, then state -> IDLE.
  - The non-owner's dout holds its previous value.
  - ram_tx_valid outside WAIT_RD is ignored; no output changes.
- Fairness: on every transition into IDLE, rr_ptr <= ~owner. This applies to pair completion, read completion and timeout.
- Owner switching after a release: a release to IDLE and a new grant to the other requester can occur on consecutive cycles (one dead cycle at most).

Optional Feature:
- Macro: SPI_ARB_RD_TIMEOUT_EN.
- With it defined:
  - The counter clears on entering WAIT_RD and increments each cycle in WAIT_RD.
  - When the counter reaches RD_TIMEOUT with no ram_tx_valid: state -> IDLE, rd_timeout pulses 1 cycle, no tx_valid is issued, and rr_ptr flips.
  - If ram_tx_valid arrives in the same cycle the count reaches RD_TIMEOUT, the data wins and there is no timeout.
- Without it: WAIT_RD waits indefinitely, rd_timeout is tied 0, and no counter is synthesised.

Decomposition:
- Package spi_arb_pkg holds:
  - the cmd localparams CMD_WR_ADDR, CMD_WR_DATA, CMD_RD_ADDR, CMD_RD_DATA;
  - state encodings ST_IDLE, ST_LOCKED, ST_WAIT_RD;
  - the field positions CMD_MSB/CMD_LSB.
- Sub-module rr_arb2: a combinational 2-requester round-robin select. Inputs are two valids and rr_ptr; outputs are a one-hot grant and the winner index.

Test Plan:
- req0 sends 0x005 (WR_ADDR) then 0x1AA (WR_DATA 0xAA) while req1 holds 0x00F valid -> req1_ready stays 0 until req0's pair is accepted; ram_din sequence is 0x005, 0x1AA, 0x00F.
- req1 sends RD_ADDR 0x205, then RD_DATA 0x300; the RAM returns ram_dout = 0xAA with ram_tx_valid 2 cycles later -> req1_dout = 0xAA with req1_tx_valid pulsed one cycle after; req0_tx_valid stays 0.
- Both requesters valid with WR_DATA words continuously from reset -> grants alternate 0, 1, 0, 1; each ram_rx_valid is 1 cycle after acceptance.
- RD_DATA accepted and ram_tx_valid never asserted (macro on, RD_TIMEOUT = 15) -> rd_timeout pulses 15 cycles after WAIT_RD entry, state returns to IDLE, and the next grant goes to the other requester. With the macro off, ready stays 0 indefinitely.
- rst asserted in LOCKED after 0x005 -> the next cycle shows all outputs 0 and state IDLE; req0 wins a subsequent simultaneous request.
- ram_tx_valid pulse while IDLE with ram_dout = 0x55 -> both tx_valid outputs stay 0 and both dout buses are unchanged.
